// File: rtl/sme_job_feeder.sv
// sme_job_feeder: buffers one tagged byte-stream match job, replays it to the
// string-matching engine as gap-free isstring/ispattern bursts, then forwards
// the SME result (or a timeout) as a one-cycle strobe.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   in_valid/in_ready          job byte handshake; in_data byte, in_kind 0=string 1=pattern,
//                              in_last marks the final (pattern) byte of the job
//   chardata/isstring/ispattern byte stream to the SME
//   sme_valid/sme_match/sme_index  SME result inputs
//   res_valid/res_match/res_index  forwarded result strobe
//   err                        pulse on dropped job or SME timeout
module sme_job_feeder #(
    parameter int unsigned STR_MAX = 32,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_kind,
    input  logic       in_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_index,
    output logic       res_valid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       err
);
    localparam int unsigned SCW = $clog2(STR_MAX + 1);
    localparam int unsigned SIW = $clog2(STR_MAX);
    localparam int unsigned PCW = $clog2(PAT_MAX + 1);
    localparam int unsigned PIW = $clog2(PAT_MAX);
    localparam int unsigned TW  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, LOAD_STR, LOAD_PAT, SEND_STR, SEND_PAT, WAIT_RES, DROP
    } state_e;

    state_e         state_q, state_d;
    logic [SCW-1:0] str_cnt_q, str_cnt_d;
    logic [PCW-1:0] pat_cnt_q, pat_cnt_d;
    logic [SCW-1:0] send_cnt_q, send_cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           have_str_q, have_str_d;
    logic [7:0]     str_buf_q [STR_MAX];
    logic [7:0]     str_buf_d [STR_MAX];
    logic [7:0]     pat_buf_q [PAT_MAX];
    logic [7:0]     pat_buf_d [PAT_MAX];
    logic           in_ready_q, in_ready_d;
    logic [7:0]     chardata_q, chardata_d;
    logic           isstring_q, isstring_d;
    logic           ispattern_q, ispattern_d;
    logic           res_valid_q, res_valid_d;
    logic           res_match_q, res_match_d;
    logic [4:0]     res_index_q, res_index_d;
    logic           err_q, err_d;

    logic           xfer;
    logic           drop;
    logic [SCW-1:0] s_cnt;
    logic [PCW-1:0] p_cnt;

    // Next-state, buffer writes and registered-output values
    always_comb begin
        state_d     = state_q;
        str_cnt_d   = str_cnt_q;
        pat_cnt_d   = pat_cnt_q;
        send_cnt_d  = send_cnt_q;
        timer_d     = timer_q;
        have_str_d  = have_str_q;
        str_buf_d   = str_buf_q;
        pat_buf_d   = pat_buf_q;
        chardata_d  = '0;
        isstring_d  = 1'b0;
        ispattern_d = 1'b0;
        res_valid_d = 1'b0;
        res_match_d = 1'b0;
        res_index_d = '0;
        err_d       = 1'b0;
        drop        = 1'b0;
        xfer        = in_valid && in_ready_q;
        // A byte accepted in IDLE opens a new job, so counts restart from zero
        s_cnt       = (state_q == IDLE) ? '0 : str_cnt_q;
        p_cnt       = (state_q == IDLE) ? '0 : pat_cnt_q;

        case (state_q)
            IDLE, LOAD_STR, LOAD_PAT: begin
                if (xfer) begin
                    if (!in_kind) begin
                        if (state_q == LOAD_PAT || in_last || s_cnt == SCW'(STR_MAX)) begin
                            drop = 1'b1;
                        end else begin
                            str_buf_d[SIW'(s_cnt)] = in_data;
                            str_cnt_d = s_cnt + SCW'(1);
                            pat_cnt_d = '0;
                            state_d   = LOAD_STR;
                        end
                    end else begin
                        if ((s_cnt == '0 && !have_str_q) || p_cnt == PCW'(PAT_MAX)) begin
                            drop = 1'b1;
                        end else begin
                            pat_buf_d[PIW'(p_cnt)] = in_data;
                            pat_cnt_d = p_cnt + PCW'(1);
                            str_cnt_d = s_cnt;
                            state_d   = LOAD_PAT;
                            if (in_last) begin
                                send_cnt_d = SCW'(1);
                                if (s_cnt != '0) begin
                                    state_d    = SEND_STR;
                                    isstring_d = 1'b1;
                                    chardata_d = str_buf_q[0];
                                end else begin
                                    // Single-byte pattern-only job: byte is not in the buffer yet
                                    state_d     = SEND_PAT;
                                    ispattern_d = 1'b1;
                                    chardata_d  = (p_cnt == '0) ? in_data : pat_buf_q[0];
                                end
                            end
                        end
                    end
                    if (drop) begin
                        err_d   = 1'b1;
                        state_d = in_last ? IDLE : DROP;
                    end
                end
            end
            DROP: begin
                if (xfer && in_last) begin
                    state_d = IDLE;
                end
            end
            SEND_STR: begin
                if (send_cnt_q < str_cnt_q) begin
                    isstring_d = 1'b1;
                    chardata_d = str_buf_q[SIW'(send_cnt_q)];
                    send_cnt_d = send_cnt_q + SCW'(1);
                end else begin
                    // Pattern burst follows the last string byte with no idle cycle
                    have_str_d  = 1'b1;
                    ispattern_d = 1'b1;
                    chardata_d  = pat_buf_q[0];
                    send_cnt_d  = SCW'(1);
                    state_d     = SEND_PAT;
                end
            end
            SEND_PAT: begin
                if (send_cnt_q < SCW'(pat_cnt_q)) begin
                    ispattern_d = 1'b1;
                    chardata_d  = pat_buf_q[PIW'(send_cnt_q)];
                    send_cnt_d  = send_cnt_q + SCW'(1);
                end else begin
                    timer_d = '0;
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (sme_valid) begin
                    res_valid_d = 1'b1;
                    res_match_d = sme_match;
                    res_index_d = sme_index;
                    state_d     = IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    res_valid_d = 1'b1;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE) || (state_d == LOAD_STR) ||
                     (state_d == LOAD_PAT) || (state_d == DROP);
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            str_cnt_q   <= '0;
            pat_cnt_q   <= '0;
            send_cnt_q  <= '0;
            timer_q     <= '0;
            have_str_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            chardata_q  <= '0;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            res_index_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            str_cnt_q   <= str_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
            send_cnt_q  <= send_cnt_d;
            timer_q     <= timer_d;
            have_str_q  <= have_str_d;
            in_ready_q  <= in_ready_d;
            chardata_q  <= chardata_d;
            isstring_q  <= isstring_d;
            ispattern_q <= ispattern_d;
            res_valid_q <= res_valid_d;
            res_match_q <= res_match_d;
            res_index_q <= res_index_d;
            err_q       <= err_d;
        end
    end

    // Job byte buffers; contents are only read below the current counts
    always_ff @(posedge clk) begin
        str_buf_q <= str_buf_d;
        pat_buf_q <= pat_buf_d;
    end

    assign in_ready  = in_ready_q;
    assign chardata  = chardata_q;
    assign isstring  = isstring_q;
    assign ispattern = ispattern_q;
    assign res_valid = res_valid_q;
    assign res_match = res_match_q;
    assign res_index = res_index_q;
    assign err       = err_q;
endmodule

// File: tb/tb_sme_job_feeder.sv
// Self-checking bench for sme_job_feeder: job bytes are pushed to a scoreboard
// as they are driven and popped as the SME-side bursts appear.
module tb_sme_job_feeder;
    logic       clk = 1'b0;
    logic       reset, in_valid, in_ready, in_kind, in_last;
    logic [7:0] in_data, chardata;
    logic       isstring, ispattern;
    logic       sme_valid, sme_match;
    logic [4:0] sme_index, res_index;
    logic       res_valid, res_match, err;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    int strobe_cnt = 0;

    logic [9:0] exp_q[$];   // {isstring, ispattern, chardata}
    logic [6:0] res_q[$];   // {res_match, res_index, err}
    bit         jk[$];
    logic [7:0] jd[$];

    sme_job_feeder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_kind(in_kind), .in_last(in_last),
        .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .sme_valid(sme_valid), .sme_match(sme_match), .sme_index(sme_index),
        .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err) err_cnt++;
        if (isstring || ispattern) strobe_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_job();
        jk.delete();
        jd.delete();
    endtask

    task automatic add(input bit k, input logic [7:0] d);
        jk.push_back(k);
        jd.push_back(d);
    endtask

    // Drive the staged job; in_last rides on the final byte
    task automatic drive_job(input bit rnd, input bit push_exp, output int stalls);
        int i = 0;
        int guard = 0;
        stalls = 0;
        if (push_exp)
            for (int k = 0; k < jk.size(); k++) exp_q.push_back({~jk[k], jk[k], jd[k]});
        while (i < jk.size() && guard < 2000) begin
            @(negedge clk);
            guard++;
            in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_kind  = jk[i];
            in_data  = jd[i];
            in_last  = (i == jk.size() - 1);
            if (in_valid) begin
                if (in_ready) i++;
                else stalls++;
            end
        end
        total++;
        if (i !== jk.size()) begin
            bad++;
            $display("FAIL drive_timeout: sent %0d want %0d bytes", i, jk.size());
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Pop expected bytes as the burst appears; a gap ends the burst short
    task automatic collect(input int n, input int budget);
        int  got = 0;
        bit  started = 0;
        bit  done = 0;
        logic [9:0] e;
        for (int c = 0; c < budget && !done; c++) begin
            if (isstring || ispattern) begin
                if (!started) begin
                    total++;
                    if (c !== 0) begin
                        bad++;
                        $display("FAIL burst_latency: got %0d want 0 cycles", c);
                    end
                end
                started = 1;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_byte: got %h", {isstring, ispattern, chardata});
                end else begin
                    e = exp_q.pop_front();
                    if ({isstring, ispattern, chardata} !== e) begin
                        bad++;
                        $display("FAIL burst_byte %0d: got %h want %h", got,
                                 {isstring, ispattern, chardata}, e);
                    end
                end
                got++;
            end else if (started) begin
                done = 1;
                total++;
                if (got !== n) begin
                    bad++;
                    $display("FAIL burst_len: got %0d want %0d", got, n);
                end
                total++;
                if (chardata !== 8'h00) begin
                    bad++;
                    $display("FAIL idle_chardata: got %h want 00", chardata);
                end
            end
            if (!done) @(negedge clk);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL burst_timeout: got %0d want %0d bytes", got, n);
            exp_q.delete();
        end
    endtask

    // Called on the first WAIT_RES cycle; optionally answers as the SME
    task automatic respond(input bit give, input bit m, input logic [4:0] idx, input int exp_c);
        int c = 0;
        bit seen = 0;
        logic [6:0] e;
        if (give) begin
            sme_valid = 1'b1;
            sme_match = m;
            sme_index = idx;
            res_q.push_back({m, idx, 1'b0});
        end else begin
            res_q.push_back({1'b0, 5'd0, 1'b1});
        end
        while (!seen && c < 200) begin
            @(negedge clk);
            c++;
            sme_valid = 1'b0;
            if (res_valid) begin
                seen = 1;
                e = res_q.pop_front();
                total++;
                if ({res_match, res_index, err} !== e) begin
                    bad++;
                    $display("FAIL result: got %h want %h", {res_match, res_index, err}, e);
                end
                total++;
                if (c !== exp_c) begin
                    bad++;
                    $display("FAIL result_latency: got %0d want %0d", c, exp_c);
                end
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL ready_after_result: got %b want 1", in_ready);
                end
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL result_timeout: got none want %h", res_q[0]);
            res_q.delete();
        end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL result_pulse: got %b want 0", res_valid);
        end
    endtask

    // Drop check: exactly one err pulse, no bytes to the SME, never stalled
    task automatic expect_drop(input string name);
        int e0, s0, st;
        e0 = err_cnt;
        s0 = strobe_cnt;
        drive_job(0, 0, st);
        repeat (5) @(negedge clk);
        total++;
        if (err_cnt - e0 !== 1) begin
            bad++;
            $display("FAIL %s_err: got %0d want 1 pulses", name, err_cnt - e0);
        end
        total++;
        if (strobe_cnt - s0 !== 0) begin
            bad++;
            $display("FAIL %s_sent: got %0d want 0 bytes", name, strobe_cnt - s0);
        end
        total++;
        if (st !== 0) begin
            bad++;
            $display("FAIL %s_ready: got %0d want 0 stalls", name, st);
        end
    endtask

    task automatic load_t1();
        clear_job();
        add(0, 8'h61); add(0, 8'h62); add(0, 8'h20); add(0, 8'h63);
        add(1, 8'h63);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_kind = 1'b0; in_last = 1'b0; in_data = '0;
        sme_valid = 1'b0; sme_match = 1'b0; sme_index = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, isstring, ispattern, res_valid, res_match, err, chardata, res_index} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {in_ready, isstring, ispattern, res_valid, res_match, err, chardata, res_index});
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_pat_no_str();
        clear_job();
        add(1, 8'h63);
        expect_drop("pat_no_str");
    endtask

    task automatic test_basic();
        int st, e0;
        e0 = err_cnt;
        load_t1();
        drive_job(0, 1, st);
        collect(5, 20);
        respond(1, 1'b1, 5'd3, 1);
        total++;
        if (err_cnt - e0 !== 0) begin
            bad++;
            $display("FAIL basic_err: got %0d want 0 pulses", err_cnt - e0);
        end
    endtask

    task automatic test_overflow();
        clear_job();
        for (int i = 0; i < 33; i++) add(0, 8'(i + 8'h40));
        add(1, 8'h41);
        expect_drop("str_overflow");
        clear_job();
        add(0, 8'h61);
        for (int i = 0; i < 9; i++) add(1, 8'(i + 8'h30));
        expect_drop("pat_overflow");
        clear_job();
        add(0, 8'h61); add(1, 8'h62); add(0, 8'h63); add(1, 8'h64);
        expect_drop("order");
        clear_job();
        add(0, 8'h61); add(0, 8'h62);
        expect_drop("last_on_string");
    endtask

    task automatic test_pat_only();
        int st;
        clear_job();
        add(1, 8'h63); add(1, 8'h78);
        drive_job(0, 1, st);
        collect(2, 20);
        respond(1, 1'b1, 5'd7, 1);
        clear_job();
        add(1, 8'h5a);
        drive_job(0, 1, st);
        collect(1, 20);
        respond(1, 1'b0, 5'd0, 1);
    endtask

    task automatic test_timeout();
        int st;
        clear_job();
        add(0, 8'h7a); add(1, 8'h7a);
        drive_job(0, 1, st);
        collect(2, 20);
        sme_match = 1'b1;
        sme_index = 5'h1f;
        respond(0, 1'b0, 5'd0, 64);
        // A result strobe while idle must not produce a result
        sme_valid = 1'b1;
        @(negedge clk);
        sme_valid = 1'b0;
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_sme_valid: got %b want 0", res_valid);
        end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_sme_valid2: got %b want 0", res_valid);
        end
    endtask

    task automatic test_reset_mid();
        int st;
        clear_job();
        for (int i = 0; i < 10; i++) add(0, 8'(i + 8'h30));
        add(1, 8'h41);
        drive_job(0, 1, st);
        total++;
        if (isstring !== 1'b1) begin
            bad++;
            $display("FAIL mid_sending: got %b want 1", isstring);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({isstring, ispattern, chardata, in_ready} !== 11'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %h want 0", {isstring, ispattern, chardata, in_ready});
        end
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        total++;
        if ({in_ready, isstring, ispattern} !== 3'b100) begin
            bad++;
            $display("FAIL mid_reset_idle: got %b want 100", {in_ready, isstring, ispattern});
        end
        // Reset forgets the string history, so a pattern-only job is dropped again
        clear_job();
        add(1, 8'h63);
        expect_drop("pat_after_reset");
    endtask

    task automatic test_back_to_back();
        int st;
        load_t1();
        drive_job(1, 1, st);
        collect(5, 20);
        respond(1, 1'b0, 5'd9, 1);
        clear_job();
        for (int i = 0; i < 32; i++) add(0, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 8; i++) add(1, 8'($urandom_range(0, 255)));
        drive_job(1, 1, st);
        collect(40, 100);
        respond(1, 1'b1, 5'd31, 1);
        load_t1();
        drive_job(0, 1, st);
        collect(5, 20);
        respond(1, 1'b1, 5'd3, 1);
    endtask

    initial begin
        test_reset();
        test_pat_no_str();
        test_basic();
        test_overflow();
        test_pat_only();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
